// File: rtl/fp16_pkg.sv
// fp16_pkg: shared constants and types for the half-precision adder.
//   EXP_W / MAN_W : exponent and mantissa field widths
//   BIAS          : exponent bias
//   QNAN / PINF   : canonical quiet NaN and +Inf encodings
//   state_t       : adder FSM states
//   operand_t     : unpacked operand (sign, exponent, 11-bit significand)
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int BIAS  = 15;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND
    } state_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W:0]   sig;
    } operand_t;

    // Subnormals are flushed: a zero exponent yields a zero significand
    // but keeps its sign, so it behaves as a signed zero downstream.
    function automatic operand_t unpack_op(input logic [15:0] v);
        operand_t o;
        o.sign = v[15];
        o.exp  = v[14:10];
        o.sig  = (v[14:10] != '0) ? {1'b1, v[9:0]} : '0;
        return o;
    endfunction

endpackage

// File: rtl/fp16_lzc.sv
// fp16_lzc: combinational leading-zero counter over a 15-bit vector.
//   vec_i   : value to scan, MSB first
//   count_o : number of zeros above the first set bit (15 when all zero)
module fp16_lzc (
    input  logic [14:0] vec_i,
    output logic [3:0]  count_o
);

    // NOTE: every variable assigned in always_comb gets a default before any
    // conditional write, otherwise synthesis infers a latch.
    always_comb begin
        count_o = 4'd15;
        // Ascending scan: the highest set bit writes last and wins.
        for (int i = 0; i < 15; i++) begin
            if (vec_i[i]) count_o = 4'(14 - i);
        end
    end

endmodule

// File: rtl/fp16_somador.sv
// fp16_somador: multicycle IEEE-754 half-precision adder/subtractor.
// Fixed latency: start accepted at edge T, done pulses after edge T+4.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   start     : request, sampled only in IDLE
//   a, b      : fp16 operands
//   busy      : high from the edge after an accepted start until done
//   done      : one-cycle pulse, resultado valid with it
//   resultado : registered rounded sum, held until the next done
//   saida_A/B : operands captured at start, held
module fp16_somador #(
    parameter int BIAS = fp16_pkg::BIAS,
    parameter int LAT  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] resultado,
    output logic [15:0] saida_A,
    output logic [15:0] saida_B
);

    import fp16_pkg::*;

    // The state sequence itself sets the latency; any other value is a misuse.
    generate
        if (LAT != 4) begin : g_lat_guard
            $error("fp16_somador: LAT is fixed at 4 by the state sequence");
        end
    endgenerate

    // Largest biased exponent: all-ones field marks Inf/NaN and overflow.
    localparam logic signed [6:0] EXP_MAX = 7'(2 * BIAS + 1);

    // Control and output registers
    state_t      state_q;
    logic        busy_q, done_q;
    logic [15:0] res_q, opa_q, opb_q;

    // Datapath registers, one group per stage
    logic               sign_q, sub_q, zsign_q, spec_q, zero_q;
    logic [15:0]        spec_val_q;
    logic signed [6:0]  exp_q;
    logic [13:0]        sx_q, sy_q, norm_q;
    logic [14:0]        sum_q;

    // Combinational next values
    operand_t           ua, ub, ux, uy;
    logic [4:0]         diff;
    logic [27:0]        wide;
    logic [13:0]        sy_d;
    logic               nan_a, nan_b, inf_a, inf_b, spec_d;
    logic [15:0]        spec_val_d;
    logic [14:0]        sum_d;
    logic [3:0]         lz, sh;
    logic [13:0]        norm_d;
    logic signed [6:0]  exp_norm_d, exp_r;
    logic [10:0]        mant;
    logic               rnd_up;
    logic [11:0]        m12;
    logic [9:0]         frac;
    logic [15:0]        res_d;

    fp16_lzc u_lzc (
        .vec_i   (sum_q),
        .count_o (lz)
    );

    always_comb begin
        // ALIGN: order by magnitude; ties keep A as X, which is harmless
        // because equal magnitudes give either the same sign or exact zero.
        ua = unpack_op(opa_q);
        ub = unpack_op(opb_q);
        if ({ub.exp, ub.sig} > {ua.exp, ua.sig}) begin
            ux = ub;
            uy = ua;
        end else begin
            ux = ua;
            uy = ub;
        end
        diff = ux.exp - uy.exp;
        // Field = {significand, G, R, S}; everything shifted past S folds into S.
        wide = {uy.sig, 17'd0} >> diff;
        if (diff >= 5'd14) sy_d = {13'd0, |uy.sig};
        else               sy_d = {wide[27:15], |wide[14:0]};

        inf_a = (opa_q[14:10] == EXP_MAX[4:0]) && (opa_q[9:0] == '0);
        inf_b = (opb_q[14:10] == EXP_MAX[4:0]) && (opb_q[9:0] == '0);
        nan_a = (opa_q[14:10] == EXP_MAX[4:0]) && (opa_q[9:0] != '0);
        nan_b = (opb_q[14:10] == EXP_MAX[4:0]) && (opb_q[9:0] != '0);
        spec_d     = nan_a | nan_b | inf_a | inf_b;
        spec_val_d = QNAN;
        if (nan_a || nan_b)                          spec_val_d = QNAN;
        else if (inf_a && inf_b && (ua.sign != ub.sign)) spec_val_d = QNAN;
        else if (inf_a)                              spec_val_d = opa_q;
        else if (inf_b)                              spec_val_d = opb_q;

        // ADD: X >= Y in magnitude, so the difference never goes negative.
        if (sub_q) sum_d = {1'b0, sx_q} - {1'b0, sy_q};
        else       sum_d = {1'b0, sx_q} + {1'b0, sy_q};

        // NORM: without a carry bit 14 is clear, so lz >= 1 and the leading
        // one lands on bit 13 after a shift of lz-1.
        sh = lz - 4'd1;
        if (sum_q[14]) begin
            norm_d     = {sum_q[14:2], |sum_q[1:0]};
            exp_norm_d = exp_q + 7'sd1;
        end else begin
            norm_d     = sum_q[13:0] << sh;
            exp_norm_d = exp_q - $signed({3'd0, sh});
        end

        // ROUND: nearest, ties to even.
        mant   = norm_q[13:3];
        rnd_up = norm_q[2] & (norm_q[1] | norm_q[0] | mant[0]);
        m12    = {1'b0, mant} + {11'd0, rnd_up};
        exp_r  = exp_q + $signed({6'd0, m12[11]});
        frac   = m12[11] ? m12[10:1] : m12[9:0];
        if (spec_q)                res_d = spec_val_q;
        else if (zero_q)           res_d = {zsign_q, 15'd0};
        else if (exp_r >= EXP_MAX) res_d = PINF | {sign_q, 15'd0};
        else if (exp_r <= 7'sd0)   res_d = {sign_q, 15'd0};
        else                       res_d = {sign_q, exp_r[4:0], frac};
    end

    // NOTE: state is updated with non-blocking assignments only, so every
    // register in this block samples the values from before the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        opa_q   <= a;
                        opb_q   <= b;
                        busy_q  <= 1'b1;
                        state_q <= ALIGN;
                    end
                end
                ALIGN:   state_q <= ADD;
                ADD:     state_q <= NORM;
                NORM:    state_q <= ROUND;
                ROUND: begin
                    res_q   <= res_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset: each is written in an earlier
    // state before any later state reads it, and the FSM reset alone is
    // enough to abandon a half-finished operation.
    always_ff @(posedge clock) begin
        case (state_q)
            ALIGN: begin
                sign_q     <= ux.sign;
                sub_q      <= ux.sign ^ uy.sign;
                zsign_q    <= ua.sign & ub.sign;
                exp_q      <= $signed({2'b00, ux.exp});
                sx_q       <= {ux.sig, 3'b000};
                sy_q       <= sy_d;
                spec_q     <= spec_d;
                spec_val_q <= spec_val_d;
            end
            ADD: sum_q <= sum_d;
            NORM: begin
                norm_q <= norm_d;
                exp_q  <= exp_norm_d;
                zero_q <= (sum_q == '0);
            end
            default: ;
        endcase
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign resultado = res_q;
    assign saida_A   = opa_q;
    assign saida_B   = opb_q;

endmodule
